// File: rtl/pixel_bit_collector.sv
// Packs a serial bit stream MSB-first into pixel words and buffers them in a FWFT FIFO.
// Optional sticky overflow/underflow status ports are enabled by defining COLLECTOR_STATUS_EN.
module pixel_bit_collector #(
  parameter int BITS_PER_PIXEL = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_bit,
  input  logic                          output_bit,
  input  logic                          frame_start,
  input  logic                          pixel_ready,
  output logic                          pixel_valid,
  output logic [BITS_PER_PIXEL-1:0]     pixel_data,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef COLLECTOR_STATUS_EN
  ,
  output logic                          overflow_flag,
  output logic                          underflow_flag
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BITS_PER_PIXEL);

  logic [CW-1:0]             bit_count;
  logic [BITS_PER_PIXEL-2:0] shreg;
  logic [BITS_PER_PIXEL-1:0] word_next;
  logic [BITS_PER_PIXEL-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;

  logic last_bit;
  logic push_cand;
  logic pop;
  logic push;
  logic not_empty;

  assign word_next = {shreg, output_bit};
  assign last_bit  = (bit_count == CW'(BITS_PER_PIXEL - 1));
  assign push_cand = valid_bit && last_bit;
  assign not_empty = (level != '0);
  assign fifo_full = (level == LW'(FIFO_DEPTH));
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a word when popped.
  assign pop  = pixel_ready && not_empty;
  assign push = push_cand && (!fifo_full || pop);

  assign pixel_valid = not_empty;
  assign pixel_data  = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      bit_count <= '0;
      shreg     <= '0;
    end else if (valid_bit) begin
      shreg     <= word_next[BITS_PER_PIXEL-2:0];
      bit_count <= last_bit ? '0 : bit_count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // Storage is deliberately not cleared; the level gate hides stale entries.
  always_ff @(posedge clk) begin
    if (push && !reset && !frame_start) mem[wr_ptr] <= word_next;
  end

`ifdef COLLECTOR_STATUS_EN
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
    end else begin
      if (push_cand && !push)         overflow_flag  <= 1'b1;
      if (pixel_ready && !not_empty)  underflow_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_bit_collector.sv
// Directed self-checking bench for pixel_bit_collector (B=4, depth 8).
// Status-flag checks are compiled in when COLLECTOR_STATUS_EN is defined.
module tb_pixel_bit_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_bit;
  logic       output_bit;
  logic       frame_start;
  logic       pixel_ready;
  logic       pixel_valid;
  logic [3:0] pixel_data;
  logic       fifo_full;
  logic [3:0] level;
`ifdef COLLECTOR_STATUS_EN
  logic       overflow_flag;
  logic       underflow_flag;
`endif

  int checks   = 0;
  int failures = 0;

  pixel_bit_collector #(.BITS_PER_PIXEL(4), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_bit   (valid_bit),
    .output_bit  (output_bit),
    .frame_start (frame_start),
    .pixel_ready (pixel_ready),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .fifo_full   (fifo_full),
    .level       (level)
`ifdef COLLECTOR_STATUS_EN
    ,
    .overflow_flag  (overflow_flag),
    .underflow_flag (underflow_flag)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Shift one 4-bit word in MSB-first; pixel_ready optionally asserted on the last bit.
  task automatic apply_stimulus(input logic [3:0] word, input logic ready_on_last);
    for (int i = 3; i >= 0; i--) begin
      valid_bit   = 1'b1;
      output_bit  = word[i];
      pixel_ready = (i == 0) ? ready_on_last : 1'b0;
      tick();
    end
    valid_bit   = 1'b0;
    output_bit  = 1'b0;
    pixel_ready = 1'b0;
  endtask

  task automatic pop_one();
    pixel_ready = 1'b1;
    tick();
    pixel_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_bit = 1'b0; output_bit = 1'b0;
    frame_start = 1'b0; pixel_ready = 1'b0;
    tick(); tick();
    check_output("rst_valid", 32'(pixel_valid), 32'd0);
    check_output("rst_data",  32'(pixel_data),  32'd0);
    check_output("rst_full",  32'(fifo_full),   32'd0);
    check_output("rst_level", 32'(level),       32'd0);
`ifdef COLLECTOR_STATUS_EN
    check_output("rst_ovf", 32'(overflow_flag),  32'd0);
    check_output("rst_unf", 32'(underflow_flag), 32'd0);
`endif
    reset = 1'b0;
    tick();

    $display("[TB] single word 1011");
    apply_stimulus(4'hB, 1'b0);
    check_output("w1_valid", 32'(pixel_valid), 32'd1);
    check_output("w1_data",  32'(pixel_data),  32'hB);
    check_output("w1_level", 32'(level),       32'd1);
    pop_one();
    check_output("w1_pop_level", 32'(level),       32'd0);
    check_output("w1_pop_valid", 32'(pixel_valid), 32'd0);
    check_output("w1_pop_data",  32'(pixel_data),  32'd0);

    $display("[TB] fill 0..7 then overflow");
    for (int w = 0; w < 8; w++) begin
      apply_stimulus(4'(w), 1'b0);
      if (w == 6) check_output("fill7_full", 32'(fifo_full), 32'd0);
    end
    check_output("fill_full",  32'(fifo_full),  32'd1);
    check_output("fill_level", 32'(level),      32'd8);
    check_output("fill_head",  32'(pixel_data), 32'd0);
    apply_stimulus(4'hF, 1'b0);
    check_output("ovf_level", 32'(level),      32'd8);
    check_output("ovf_head",  32'(pixel_data), 32'd0);
`ifdef COLLECTOR_STATUS_EN
    check_output("ovf_flag", 32'(overflow_flag), 32'd1);
`endif
    for (int w = 0; w < 8; w++) begin
      check_output("drain_data", 32'(pixel_data), 32'(w));
      pop_one();
    end
    check_output("drain_valid", 32'(pixel_valid), 32'd0);
    check_output("drain_level", 32'(level),       32'd0);

    $display("[TB] push and pop while full");
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
`ifdef COLLECTOR_STATUS_EN
    check_output("fs_ovf_clr", 32'(overflow_flag), 32'd0);
`endif
    for (int w = 0; w < 8; w++) apply_stimulus(4'(w + 1), 1'b0);
    check_output("pp_full_before", 32'(fifo_full), 32'd1);
    apply_stimulus(4'hA, 1'b1);
    check_output("pp_level", 32'(level),      32'd8);
    check_output("pp_full",  32'(fifo_full),  32'd1);
    check_output("pp_head",  32'(pixel_data), 32'd2);
`ifdef COLLECTOR_STATUS_EN
    check_output("pp_no_ovf", 32'(overflow_flag), 32'd0);
`endif
    for (int w = 0; w < 8; w++) begin
      check_output("pp_drain", 32'(pixel_data), (w == 7) ? 32'hA : 32'(w + 2));
      pop_one();
    end
    check_output("pp_empty", 32'(level), 32'd0);

    $display("[TB] ready while empty");
    apply_stimulus(4'h6, 1'b1);
    check_output("unf_valid", 32'(pixel_valid), 32'd1);
    check_output("unf_level", 32'(level),       32'd1);
    check_output("unf_data",  32'(pixel_data),  32'h6);
`ifdef COLLECTOR_STATUS_EN
    check_output("unf_flag", 32'(underflow_flag), 32'd1);
`endif
    pop_one();

    $display("[TB] frame_start mid-word");
    apply_stimulus(4'h5, 1'b0);
    valid_bit = 1'b1; output_bit = 1'b1;
    tick(); tick();
    valid_bit = 1'b0; output_bit = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_output("fs_level", 32'(level),       32'd0);
    check_output("fs_valid", 32'(pixel_valid), 32'd0);
    check_output("fs_data",  32'(pixel_data),  32'd0);
`ifdef COLLECTOR_STATUS_EN
    check_output("fs_unf_clr", 32'(underflow_flag), 32'd0);
`endif
    apply_stimulus(4'h3, 1'b0);
    check_output("fs_word_data",  32'(pixel_data), 32'h3);
    check_output("fs_word_level", 32'(level),      32'd1);
    pop_one();

    $display("[TB] reset with buffered words");
    apply_stimulus(4'h7, 1'b0);
    apply_stimulus(4'h8, 1'b0);
    valid_bit = 1'b1; output_bit = 1'b1;
    tick();
    valid_bit = 1'b0; output_bit = 1'b0;
    check_output("pre_rst_level", 32'(level), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("rst2_valid", 32'(pixel_valid), 32'd0);
    check_output("rst2_level", 32'(level),       32'd0);
    check_output("rst2_data",  32'(pixel_data),  32'd0);
    tick();
    check_output("rst2_hold_valid", 32'(pixel_valid), 32'd0);
    apply_stimulus(4'h9, 1'b0);
    check_output("post_rst_data",  32'(pixel_data), 32'h9);
    check_output("post_rst_level", 32'(level),      32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
